counter_sched: RTL

Round-robin scheduler that shares one up/down counter between two requesters. Each requester submits a burst command (direction + step count) over a valid/ready handshake. The block grants one requester at a time and steps the owned counter once per clock until the burst completes. It then pulses a done flag tagged with the requester ID. It sits in front of the counter datapath and is the only writer of its count value.

---
 rtl/counter_sched.sv | 93 +++++++++
 1 files changed

// File: rtl/counter_sched.sv
// Two-requester round-robin front end for a shared up/down counter.
// Each accepted command steps the counter once per clock, then pulses done.
module counter_sched #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic             done_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             dir_q;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel_dir;
  logic [LEN_W-1:0] sel_len;

  // last_grant resets to 1 so that requester 0 wins the first tie
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    accept = req0_ready || req1_ready;
    sel_dir = req1_ready ? req1_dir : req0_dir;
    sel_len = req1_ready ? req1_len : req0_len;
  end

  assign busy    = (state == RUN) || (state == DONE);
  assign done    = (state == DONE);
  assign done_id = owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      remaining  <= '0;
      dir_q      <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q      <= sel_dir;
            remaining  <= sel_len;
            owner      <= req1_ready;
            last_grant <= req1_ready;
            state      <= (sel_len == LEN_ZERO) ? DONE : RUN;
          end
        end
        RUN: begin
          count     <= dir_q ? (count + CNT_ONE) : (count - CNT_ONE);
          remaining <= remaining - LEN_ONE;
          if (remaining == LEN_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
